hazard_stall_controller: RTL and testbench

- Control side of the pipeline registers. It drives the write-enable, bubble, flush and hold inputs of IF/ID, ID/EX, EX/MEM and MEM/WB, plus PC write and PC-source select.
- Detects load-use hazards (ID/EX load vs IF/ID consumer) and taken branches resolved in MEM.
- Freezes the whole pipeline while data memory is busy, with a watchdog and saturating stall/flush statistics counters.

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/sat_counter.sv | 24 ++
 rtl/hazard_stall_controller.sv | 146 ++++++++++++++
 tb/tb_hazard_stall_controller.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg
//   Shared types and constants for the hazard/stall controller.
//   - hz_state_e : memory-freeze FSM state (RUN, FREEZE)
//   - REG_ZERO   : architectural zero register, never a hazard source
package hazard_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Load-use check: a load in ID/EX whose destination is read by the
  // instruction in IF/ID. rt only counts when the consumer really reads it.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] ld_rt,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       uses_rt
  );
    return mem_read && (ld_rt != REG_ZERO) &&
           ((ld_rt == rs) || (uses_rt && (ld_rt == rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter
//   Saturating up-counter; sticks at all-ones instead of wrapping.
//   Ports:
//     clock  in   clock
//     reset  in   synchronous active-high clear
//     inc    in   count this cycle
//     count  out  current value (W bits)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset)
      count <= '0;
    else if (inc && !(&count))
      count <= count + W'(1);
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
//   Drives the pipeline-register controls for a 5-stage pipe:
//   load-use stall, taken-branch flush (branch resolved in MEM) and a
//   whole-pipe freeze while data memory is busy, with a sticky watchdog
//   and saturating stall/flush statistics.
//   Ports:
//     clock, reset           clock, synchronous active-high reset
//     if_id_rs/rt/uses_rt    source fields of the IF/ID instruction
//     id_ex_mem_read/rt      load in ID/EX and its destination
//     branch_ex_mem,
//     alu_zero_ex_mem        branch resolution in EX/MEM
//     mem_busy               data memory not ready
//     pc_write, pc_src       PC enable / branch-target select
//     if_id_write            IF/ID enable
//     ctrl_hazard_bubble     zero control fields entering ID/EX
//     flush_if_id/id_ex/ex_mem  load NOP/bubble into that register
//     pipe_hold              ID/EX, EX/MEM, MEM/WB hold
//     stall_count, flush_count  saturating statistics
//     timeout_err            sticky: mem_busy held TIMEOUT cycles
module hazard_stall_controller
  import hazard_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [4:0]         if_id_rs,
  input  logic [4:0]         if_id_rt,
  input  logic               if_id_uses_rt,
  input  logic               id_ex_mem_read,
  input  logic [4:0]         id_ex_rt,
  input  logic               branch_ex_mem,
  input  logic               alu_zero_ex_mem,
  input  logic               mem_busy,
  output logic               pc_write,
  output logic               pc_src,
  output logic               if_id_write,
  output logic               ctrl_hazard_bubble,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               flush_ex_mem,
  output logic               pipe_hold,
  output logic [COUNT_W-1:0] stall_count,
  output logic [COUNT_W-1:0] flush_count,
  output logic               timeout_err
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT);

  hz_state_e          state;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] timer_nxt;

  logic load_use;
  logic taken;
  logic stall_inc;
  logic flush_inc;

  assign load_use = load_use_hit(id_ex_mem_read, id_ex_rt, if_id_rs,
                                 if_id_rt, if_id_uses_rt);
  assign taken    = branch_ex_mem && alu_zero_ex_mem;

  // Priority: reset > mem_busy > taken > load_use. Busy wins over taken so
  // the branch stays in EX/MEM (held) and resolves once memory is ready.
  // Taken wins over load_use: the consumer is on the squashed path.
  always_comb begin
    pc_write           = 1'b1;
    pc_src             = 1'b0;
    if_id_write        = 1'b1;
    ctrl_hazard_bubble = 1'b0;
    flush_if_id        = 1'b0;
    flush_id_ex        = 1'b0;
    flush_ex_mem       = 1'b0;
    pipe_hold          = 1'b0;
    stall_inc          = 1'b0;
    flush_inc          = 1'b0;
    if (reset) begin
      // Drain every stage to NOPs while reset is held.
      pc_write           = 1'b0;
      if_id_write        = 1'b0;
      ctrl_hazard_bubble = 1'b1;
      flush_if_id        = 1'b1;
      flush_id_ex        = 1'b1;
      flush_ex_mem       = 1'b1;
    end else if (mem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (taken) begin
      pc_src             = 1'b1;
      flush_if_id        = 1'b1;
      flush_id_ex        = 1'b1;
      flush_ex_mem       = 1'b1;
      ctrl_hazard_bubble = 1'b1;
      flush_inc          = 1'b1;
    end else if (load_use) begin
      // One cycle is enough: next cycle ID/EX holds the bubble, not the load.
      pc_write           = 1'b0;
      if_id_write        = 1'b0;
      ctrl_hazard_bubble = 1'b1;
      stall_inc          = 1'b1;
    end
  end

  // Timer counts consecutive mem_busy edges and clears whenever memory is
  // ready, so it reads TIMEOUT exactly after TIMEOUT busy edges in a row.
  always_comb begin
    timer_nxt = '0;
    if (mem_busy)
      timer_nxt = (timer == TIMER_MAX) ? timer : timer + TIMER_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        RUN:     state <= mem_busy ? FREEZE : RUN;
        FREEZE:  state <= mem_busy ? FREEZE : RUN;
        default: state <= RUN;
      endcase
      timer <= timer_nxt;
      if (timer_nxt == TIMER_MAX)
        timeout_err <= 1'b1;
    end
  end

  sat_counter #(.W(COUNT_W)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.W(COUNT_W)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;
  import hazard_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  if_id_rs, if_id_rt, id_ex_rt;
  logic        if_id_uses_rt, id_ex_mem_read, branch_ex_mem, alu_zero_ex_mem, mem_busy;

  logic        pc_write, pc_src, if_id_write, ctrl_hazard_bubble;
  logic        flush_if_id, flush_id_ex, flush_ex_mem, pipe_hold, timeout_err;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_write, s_pc_src, s_if_id_write, s_bubble;
  logic        s_fl_if_id, s_fl_id_ex, s_fl_ex_mem, s_hold, s_timeout;
  logic [1:0]  s_stall_count, s_flush_count;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  hazard_stall_controller dut (
    .clock(clock), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .branch_ex_mem(branch_ex_mem), .alu_zero_ex_mem(alu_zero_ex_mem),
    .mem_busy(mem_busy),
    .pc_write(pc_write), .pc_src(pc_src), .if_id_write(if_id_write),
    .ctrl_hazard_bubble(ctrl_hazard_bubble),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .pipe_hold(pipe_hold), .stall_count(stall_count), .flush_count(flush_count),
    .timeout_err(timeout_err)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  hazard_stall_controller #(.COUNT_W(2)) u_sat (
    .clock(clock), .reset(reset),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt),
    .branch_ex_mem(branch_ex_mem), .alu_zero_ex_mem(alu_zero_ex_mem),
    .mem_busy(mem_busy),
    .pc_write(s_pc_write), .pc_src(s_pc_src), .if_id_write(s_if_id_write),
    .ctrl_hazard_bubble(s_bubble),
    .flush_if_id(s_fl_if_id), .flush_id_ex(s_fl_id_ex), .flush_ex_mem(s_fl_ex_mem),
    .pipe_hold(s_hold), .stall_count(s_stall_count), .flush_count(s_flush_count),
    .timeout_err(s_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic idle();
    if_id_rs = 5'd1; if_id_rt = 5'd3; if_id_uses_rt = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_rt = 5'd0;
    branch_ex_mem = 1'b0; alu_zero_ex_mem = 1'b0; mem_busy = 1'b0;
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Check all eight combinational controls as one packed vector:
  // {pc_write, pc_src, if_id_write, bubble, fl_if_id, fl_id_ex, fl_ex_mem, hold}
  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    #1;
    chk(tag, 32'({pc_write, pc_src, if_id_write, ctrl_hazard_bubble,
                  flush_if_id, flush_id_ex, flush_ex_mem, pipe_hold}), 32'(exp));
  endtask

  localparam logic [7:0] C_DEF   = 8'b1010_0000;
  localparam logic [7:0] C_RST   = 8'b0001_1110;
  localparam logic [7:0] C_BUSY  = 8'b0000_0001;
  localparam logic [7:0] C_TAKEN = 8'b1111_1110;
  localparam logic [7:0] C_STALL = 8'b0001_0000;

  initial begin
    idle();
    reset = 1'b1;
    tick(); tick();
    chk_ctl("reset_ctl", C_RST);
    chk("reset_stall_cnt", 32'(stall_count), 0);
    chk("reset_flush_cnt", 32'(flush_count), 0);
    chk("reset_err", 32'(timeout_err), 0);
    reset = 1'b0;
    chk_ctl("idle_ctl", C_DEF);

    // Load-use on rs
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd2; if_id_rs = 5'd2;
    chk_ctl("lu_rs_ctl", C_STALL);
    tick();
    id_ex_mem_read = 1'b0;
    chk_ctl("lu_after_ctl", C_DEF);
    chk("lu_stall_cnt", 32'(stall_count), 1);

    // Suppression cases
    idle();
    id_ex_mem_read = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0;
    chk_ctl("r0_no_stall", C_DEF);
    if_id_rs = 5'd1; id_ex_rt = 5'd5; if_id_rt = 5'd5; if_id_uses_rt = 1'b0;
    chk_ctl("rt_unused_no_stall", C_DEF);
    if_id_uses_rt = 1'b1;
    chk_ctl("rt_used_stall", C_STALL);
    tick();
    chk("rt_stall_cnt", 32'(stall_count), 2);

    // Taken branch + load_use same cycle: flush wins
    branch_ex_mem = 1'b1; alu_zero_ex_mem = 1'b1;
    chk_ctl("taken_over_lu", C_TAKEN);
    tick();
    chk("taken_flush_cnt", 32'(flush_count), 1);
    chk("taken_stall_cnt", 32'(stall_count), 2);
    idle();
    branch_ex_mem = 1'b1; alu_zero_ex_mem = 1'b0;
    chk_ctl("not_taken_ctl", C_DEF);

    // Taken branch deferred by mem_busy for 3 cycles
    idle();
    branch_ex_mem = 1'b1; alu_zero_ex_mem = 1'b1; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_ctl($sformatf("busy_defer_%0d", i), C_BUSY);
      tick();
    end
    chk("busy_defer_flush_cnt", 32'(flush_count), 1);
    chk("busy_state_freeze", 32'(dut.state), 32'(FREEZE));
    mem_busy = 1'b0;
    chk_ctl("deferred_flush", C_TAKEN);
    tick();
    chk("deferred_flush_cnt", 32'(flush_count), 2);
    idle();
    chk_ctl("after_flush_ctl", C_DEF);
    tick();
    chk("flush_once_cnt", 32'(flush_count), 2);
    chk("state_run", 32'(dut.state), 32'(RUN));

    // Watchdog: 15 busy edges is not enough
    mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("wd_15_err", 32'(timeout_err), 0);
    mem_busy = 1'b0;
    tick();
    chk("wd_15_drop_err", 32'(timeout_err), 0);
    // 16 consecutive busy edges sets it
    mem_busy = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("wd_pre16_err", 32'(timeout_err), 0);
    tick();
    chk("wd_16_err", 32'(timeout_err), 1);
    chk_ctl("wd_still_frozen", C_BUSY);
    mem_busy = 1'b0;
    tick();
    chk("wd_sticky", 32'(timeout_err), 1);

    // Reset mid-freeze
    mem_busy = 1'b1;
    tick(); tick();
    reset = 1'b1;
    chk_ctl("reset_over_busy", C_RST);
    tick();
    reset = 1'b0;
    mem_busy = 1'b0;
    chk("rst_err", 32'(timeout_err), 0);
    chk("rst_stall_cnt", 32'(stall_count), 0);
    chk("rst_flush_cnt", 32'(flush_count), 0);
    chk("rst_state", 32'(dut.state), 32'(RUN));

    // Saturation: 5 separated load-use stalls on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      idle();
      id_ex_mem_read = 1'b1; id_ex_rt = 5'd7; if_id_rs = 5'd7;
      tick();
      idle();
      tick();
    end
    chk("sat_stall_cnt", 32'(s_stall_count), 3);
    chk("wide_stall_cnt", 32'(stall_count), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
